// File: rtl/rom_burst.sv
// rom_burst: synchronous ROM that answers one request with a burst of 1..MAX_BURST words.
// Responses pass through a 2-entry buffer, so response backpressure never drops a beat.
// Defining ROM_BOUNDS_CHK_EN adds the RSP_ERR port and returns zero data for
// out-of-range start addresses.
module rom_burst #(
    parameter int unsigned DW        = 32,
    parameter int unsigned MEM_WORDS = 8192,
    parameter int unsigned AW        = 13,
    parameter int unsigned MAX_BURST = 8,
    parameter int unsigned LW        = 3,
    parameter string       INIT_FILE = ""
) (
    input  logic          CLK,
    input  logic          RESETn,
    input  logic          REQ_VALID,
    output logic          REQ_READY,
    input  logic [AW-1:0] REQ_ADDR,
    input  logic [LW-1:0] REQ_LEN,
    output logic          RSP_VALID,
    input  logic          RSP_READY,
    output logic [DW-1:0] RSP_DATA,
    output logic          RSP_LAST,
`ifdef ROM_BOUNDS_CHK_EN
    output logic          RSP_ERR,
`endif
    output logic          BUSY
);

    // Remaining-beat counter must hold MAX_BURST itself.
    localparam int unsigned   RW        = $clog2(MAX_BURST) + 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_WORDS - 1);

    typedef enum logic [1:0] {StIdle, StBurst, StDrain} state_e;

    logic [DW-1:0] mem [MEM_WORDS];

    state_e        state_q;
    logic [AW-1:0] addr_q;
    logic [RW-1:0] rem_q;

    // Read stage: registered array output waiting to enter the buffer.
    logic          rd_valid_q;
    logic          rd_last_q;
    logic [DW-1:0] rd_data_q;

    // Two-entry response buffer.
    logic [1:0]    cnt_q;
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [DW-1:0] buf_data_q [2];
    logic          buf_last_q [2];

`ifdef ROM_BOUNDS_CHK_EN
    logic          err_q;
    logic          rd_err_q;
    logic          buf_err_q [2];
`endif

    logic          pop;
    logic          issue;
    logic [1:0]    cnt_d;
    logic [2:0]    occ;
    logic [AW-1:0] addr_inc;

    // Flow control: issue a read only if a buffer slot is guaranteed for it.
    always_comb begin
        RSP_VALID = (cnt_q != 2'd0);
        pop       = RSP_VALID && RSP_READY;
        occ       = {1'b0, cnt_q} + {2'b00, rd_valid_q} - {2'b00, pop};
        issue     = (state_q == StBurst) && (occ < 3'd2);
        cnt_d     = cnt_q + {1'b0, rd_valid_q} - {1'b0, pop};
        addr_inc  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
    end

    assign REQ_READY = RESETn && (state_q == StIdle);
    assign BUSY      = (state_q != StIdle);
    assign RSP_DATA  = RSP_VALID ? buf_data_q[rd_ptr_q] : '0;
    assign RSP_LAST  = RSP_VALID && buf_last_q[rd_ptr_q];
`ifdef ROM_BOUNDS_CHK_EN
    assign RSP_ERR   = RSP_VALID && buf_err_q[rd_ptr_q];
`endif

    // Burst sequencer: accept a request, walk the addresses, then wait for the buffer to drain.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q <= StIdle;
            addr_q  <= '0;
            rem_q   <= '0;
`ifdef ROM_BOUNDS_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (REQ_VALID) begin
                        state_q <= StBurst;
                        addr_q  <= REQ_ADDR;
                        rem_q   <= RW'(REQ_LEN) + RW'(1);
`ifdef ROM_BOUNDS_CHK_EN
                        // Wrap keeps in-range bursts in range, so only the start matters.
                        err_q   <= (32'(REQ_ADDR) >= MEM_WORDS);
`endif
                    end
                end
                StBurst: begin
                    if (issue) begin
                        addr_q <= addr_inc;
                        rem_q  <= rem_q - 1'b1;
                        if (rem_q == RW'(1)) state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (cnt_d == 2'd0) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Read-stage control: track the read in flight and whether it ends the burst.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
`ifdef ROM_BOUNDS_CHK_EN
            rd_err_q   <= 1'b0;
`endif
        end else begin
            rd_valid_q <= issue;
            if (issue) begin
                rd_last_q <= (rem_q == RW'(1));
`ifdef ROM_BOUNDS_CHK_EN
                rd_err_q  <= err_q;
`endif
            end
        end
    end

    // Array read port, kept free of reset so it can map onto block RAM.
    always_ff @(posedge CLK) begin
        if (issue) rd_data_q <= mem[addr_q];
    end

    // Response buffer: push the read stage, pop on handshake; push and pop may coincide.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            cnt_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (rd_valid_q) begin
`ifdef ROM_BOUNDS_CHK_EN
                buf_data_q[wr_ptr_q] <= rd_err_q ? '0 : rd_data_q;
                buf_err_q[wr_ptr_q]  <= rd_err_q;
`else
                buf_data_q[wr_ptr_q] <= rd_data_q;
`endif
                buf_last_q[wr_ptr_q] <= rd_last_q;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_rom_burst.sv
// tb_rom_burst: randomized bursts checked against a queue-based reference model of rom_burst,
// plus directed bursts with hand-written expected words.
module tb_rom_burst;

    localparam int AW = 13;
`ifdef ROM_BOUNDS_CHK_EN
    localparam int MEM_WORDS = 6000;
    localparam int ADDR_MAX  = (1 << AW) - 1;
`else
    localparam int MEM_WORDS = 8192;
    localparam int ADDR_MAX  = MEM_WORDS - 1;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        err;
    } beat_t;

    logic          CLK = 1'b0;
    logic          RESETn;
    logic          REQ_VALID;
    logic          REQ_READY;
    logic [AW-1:0] REQ_ADDR;
    logic [2:0]    REQ_LEN;
    logic          RSP_VALID;
    logic          RSP_READY = 1'b1;
    logic [31:0]   RSP_DATA;
    logic          RSP_LAST;
    logic          BUSY;
`ifdef ROM_BOUNDS_CHK_EN
    logic          RSP_ERR;
`endif

    int    n_checks = 0;
    int    n_fail   = 0;
    logic  mon_en   = 1'b0;
    logic  model_busy = 1'b0;
    beat_t exp_q[$];
    logic [31:0] ref_mem [1 << AW];
    logic [31:0] lit [8];
    logic        lit_err = 1'b0;
    int          rdy_mode = 0;
    int          pat_i = 0;
    logic [5:0]  pat = 6'b101001;   // RSP_READY sequence 1,0,0,1,0,1 read from bit 0 upward

    rom_burst #(.MEM_WORDS(MEM_WORDS)) dut (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_LEN   (REQ_LEN),
        .RSP_VALID (RSP_VALID),
        .RSP_READY (RSP_READY),
        .RSP_DATA  (RSP_DATA),
        .RSP_LAST  (RSP_LAST),
`ifdef ROM_BOUNDS_CHK_EN
        .RSP_ERR   (RSP_ERR),
`endif
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_word(input int a, input logic [31:0] v);
        ref_mem[a]  = v;
        dut.mem[a]  = v;
    endtask

    // Reference model: a burst is the list of words from the start address with wrap at
    // MEM_WORDS; BUSY/!REQ_READY hold from acceptance until the last beat is consumed.
    always @(negedge CLK) begin
        if (mon_en) begin
            check("busy", 64'(BUSY), 64'(model_busy));
            check("req_ready", 64'(REQ_READY), 64'(RESETn && !model_busy));
            if (RSP_VALID) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(RSP_VALID), 64'(0));
                end else begin
                    check("rsp_data", 64'(RSP_DATA), 64'(exp_q[0].data));
                    check("rsp_last", 64'(RSP_LAST), 64'(exp_q[0].last));
`ifdef ROM_BOUNDS_CHK_EN
                    check("rsp_err", 64'(RSP_ERR), 64'(exp_q[0].err));
`endif
                    if (RSP_READY && RESETn) begin
                        void'(exp_q.pop_front());
                        if (exp_q.size() == 0) model_busy = 1'b0;
                    end
                end
            end
            if (!RESETn) begin
                exp_q.delete();
                model_busy = 1'b0;
            end else if (REQ_VALID && REQ_READY) begin
                int   a;
                logic oor;
                beat_t e;
                a   = int'(REQ_ADDR);
                oor = (a >= MEM_WORDS);
                for (int k = 0; k <= int'(REQ_LEN); k++) begin
                    e.data = oor ? 32'h0 : ref_mem[a];
                    e.last = (k == int'(REQ_LEN));
                    e.err  = oor;
                    exp_q.push_back(e);
                    a = (a + 1) % MEM_WORDS;
                end
                model_busy = 1'b1;
            end
        end
    end

    // Response-side ready: steady, random, or the fixed stall pattern.
    always @(posedge CLK) begin
        #1;
        if (rdy_mode == 0) begin
            RSP_READY = 1'b1;
        end else if (rdy_mode == 1) begin
            RSP_READY = 1'($urandom_range(0, 1));
        end else begin
            RSP_READY = pat[pat_i];
            pat_i     = (pat_i + 1) % 6;
        end
    end

    // Holds the request until it is taken; returns just after the acceptance edge.
    task automatic send_req(input int a, input int l);
        int n = 0;
        REQ_VALID = 1'b1;
        REQ_ADDR  = AW'(a);
        REQ_LEN   = 3'(l);
        @(negedge CLK);
        while (!REQ_READY && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (!REQ_READY) check("req_accept_timeout", 64'(REQ_READY), 64'(1));
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || BUSY) && n < 1000) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 1000) check("idle_timeout", 64'(BUSY), 64'(0));
        @(posedge CLK);
        #1;
    endtask

    // Full-rate burst against the literal words in lit[]; pins latency and gap-free beats.
    task automatic full_rate_check(input string name, input int a, input int len);
        send_req(a, len);
        @(negedge CLK);
        check({name, "_lat1"}, 64'(RSP_VALID), 64'(0));
        @(negedge CLK);
        check({name, "_lat2"}, 64'(RSP_VALID), 64'(0));
        for (int k = 0; k <= len; k++) begin
            @(negedge CLK);
            check({name, "_valid"}, 64'(RSP_VALID), 64'(1));
            check({name, "_data"}, 64'(RSP_DATA), 64'(lit[k]));
            check({name, "_last"}, 64'(RSP_LAST), 64'(k == len));
            check({name, "_busy"}, 64'(BUSY), 64'(1));
`ifdef ROM_BOUNDS_CHK_EN
            check({name, "_err"}, 64'(RSP_ERR), 64'(lit_err));
`endif
        end
        @(negedge CLK);
        check({name, "_ready_after"}, 64'(REQ_READY), 64'(1));
        check({name, "_idle_valid"}, 64'(RSP_VALID), 64'(0));
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RESETn    = 1'b0;
        REQ_VALID = 1'b0;
        REQ_ADDR  = '0;
        REQ_LEN   = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            ref_mem[i] = $urandom;
            if (i < MEM_WORDS) dut.mem[i] = ref_mem[i];
        end

        // Reset state.
        repeat (3) @(posedge CLK);
        mon_en = 1'b1;
        @(negedge CLK);
        check("rst_valid", 64'(RSP_VALID), 64'(0));
        check("rst_last", 64'(RSP_LAST), 64'(0));
        check("rst_data", 64'(RSP_DATA), 64'(0));
        check("rst_busy", 64'(BUSY), 64'(0));
        check("rst_ready", 64'(REQ_READY), 64'(0));
        @(posedge CLK);
        #1;
        RESETn = 1'b1;
        @(negedge CLK);
        check("ready_after_reset", 64'(REQ_READY), 64'(1));
        @(posedge CLK);
        #1;

        // Single beat.
        set_word(5, 32'hDEADBEEF);
        lit[0] = 32'hDEADBEEF;
        full_rate_check("single", 5, 0);

        // Full-rate eight-beat burst over word[i] = i.
        for (int k = 0; k < 8; k++) begin
            set_word(100 + k, 32'(100 + k));
            lit[k] = 32'(100 + k);
        end
        full_rate_check("burst8", 100, 7);

        // Wrap past the last word.
        set_word(MEM_WORDS - 2, 32'hA5A5_0001);
        set_word(MEM_WORDS - 1, 32'hA5A5_0002);
        set_word(0, 32'hA5A5_0003);
        set_word(1, 32'hA5A5_0004);
        lit[0] = 32'hA5A5_0001;
        lit[1] = 32'hA5A5_0002;
        lit[2] = 32'hA5A5_0003;
        lit[3] = 32'hA5A5_0004;
        full_rate_check("wrap", MEM_WORDS - 2, 3);

`ifdef ROM_BOUNDS_CHK_EN
        lit[0]  = 32'h0;
        lit[1]  = 32'h0;
        lit_err = 1'b1;
        full_rate_check("oob", 7000, 1);
        set_word(10, 32'h1234_5678);
        lit[0]  = 32'h1234_5678;
        lit_err = 1'b0;
        full_rate_check("inb", 10, 0);
`endif

        // Backpressure with the fixed stall pattern; the model checks order and stability.
        rdy_mode = 2;
        pat_i    = 0;
        send_req(0, 7);
        wait_idle();
        rdy_mode = 0;
        @(posedge CLK);
        #1;

        // Reset after the third beat has been consumed.
        send_req(0, 7);
        repeat (5) @(negedge CLK);
        @(posedge CLK);
        #1;
        RESETn = 1'b0;
        @(negedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        check("midrst_valid", 64'(RSP_VALID), 64'(0));
        check("midrst_busy", 64'(BUSY), 64'(0));
        check("midrst_data", 64'(RSP_DATA), 64'(0));
        @(posedge CLK);
        #1;
        RESETn = 1'b1;
        @(negedge CLK);
        check("midrst_ready", 64'(REQ_READY), 64'(1));
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("midrst_no_residual", 64'(RSP_VALID), 64'(0));
        end
        @(posedge CLK);
        #1;

        // Randomized bursts, issued back to back where the DUT allows.
        for (int it = 0; it < 60; it++) begin
            int a;
            int l;
            rdy_mode = int'($urandom_range(0, 2));
            pat_i    = 0;
            if ($urandom_range(0, 3) == 0) a = MEM_WORDS - 1 - int'($urandom_range(0, 3));
            else a = int'($urandom_range(0, ADDR_MAX));
            l = int'($urandom_range(0, 7));
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            #1;
            send_req(a, l);
        end
        wait_idle();
        rdy_mode = 0;
        repeat (3) @(posedge CLK);

        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
